id_ex_alu_ctrl_stage: RTL and testbench

Decode-side producer of the 4-bit alu_ctrl code, register-operand and immediate selection for the 32-bit integer execute stage, including the compare unit (SLT = 4'b1000, SLTU = 4'b1001).
- Decodes OP, OP-IMM and BRANCH instructions.
- Selects operands.
- Registers the result in a one-entry ID/EX pipeline slot with valid/ready handshake and flush.
- Sits between the register-file read and the execute-stage ALU/compare units.

---
 rtl/id_ex_alu_ctrl_stage_pkg.sv | 26 ++
 rtl/id_ex_alu_ctrl_stage_if.sv | 32 +++
 rtl/id_ex_alu_ctrl_stage_decode.sv | 120 ++++++++++++
 rtl/id_ex_alu_ctrl_stage.sv | 82 ++++++++
 tb/tb_id_ex_alu_ctrl_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_alu_ctrl_stage_pkg.sv
// Shared execute-stage constants: alu_ctrl encoding, major opcodes, funct7 forms.
// The ALU and compare unit import the same encodings from here.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ALU_CTRL_W   = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/id_ex_alu_ctrl_stage_if.sv
// ID/EX slot bus: upstream instruction/operand handshake and downstream decoded entry.
interface id_ex_alu_ctrl_stage_if
    import alu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = ALU_CTRL_W
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   rs_1_data;
    logic [XLEN-1:0]   rs_2_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              is_branch;
    logic [2:0]        br_funct3;
    logic              illegal;

    modport master (
        output flush, in_valid, instr, rs_1_data, rs_2_data, out_ready,
        input  in_ready, out_valid, alu_ctrl, op_a, op_b, is_branch, br_funct3, illegal
    );

    modport slave (
        input  flush, in_valid, instr, rs_1_data, rs_2_data, out_ready,
        output in_ready, out_valid, alu_ctrl, op_a, op_b, is_branch, br_funct3, illegal
    );
endinterface

// File: rtl/id_ex_alu_ctrl_stage_decode.sv
// Combinational decode of OP / OP-IMM / BRANCH into alu_ctrl and operand selection.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   rs_1_data,
    input  logic [XLEN-1:0]   rs_2_data,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic              is_branch,
    output logic [2:0]        br_funct3,
    output logic              illegal
);
    logic [6:0]        opcode;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_sh;
    logic [CTRL_W-1:0] ctrl;
    logic              legal;
    logic              use_imm;
    logic              shift_imm;
    logic              branch;
    logic              unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};
    // Register indices are resolved by the register file before this stage.
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        ctrl      = '0;
        legal     = 1'b0;
        use_imm   = 1'b0;
        shift_imm = 1'b0;
        branch    = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000: ctrl = ALU_ADD;
                        3'b001: ctrl = ALU_SLL;
                        3'b010: ctrl = ALU_SLT;
                        3'b011: ctrl = ALU_SLTU;
                        3'b100: ctrl = ALU_XOR;
                        3'b101: ctrl = ALU_SRL;
                        3'b110: ctrl = ALU_OR;
                        default: ctrl = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    ctrl = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    ctrl = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                legal   = 1'b1;
                use_imm = 1'b1;
                case (funct3)
                    3'b000: ctrl = ALU_ADD;
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b110: ctrl = ALU_OR;
                    3'b111: ctrl = ALU_AND;
                    3'b001: begin
                        shift_imm = 1'b1;
                        ctrl      = ALU_SLL;
                        legal     = (funct7 == F7_BASE);
                    end
                    default: begin
                        shift_imm = 1'b1;
                        if (funct7 == F7_BASE)     ctrl = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl = ALU_SRA;
                        else                       legal = 1'b0;
                    end
                endcase
            end
            OPC_BRANCH: begin
                legal  = 1'b1;
                branch = 1'b1;
                // Equality via SUB, signed/unsigned ordering via the compare unit.
                case (funct3)
                    3'b000, 3'b001: ctrl = ALU_SUB;
                    3'b100, 3'b101: ctrl = ALU_SLT;
                    3'b110, 3'b111: ctrl = ALU_SLTU;
                    default:        legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_ctrl  = '0;
        op_a      = '0;
        op_b      = '0;
        is_branch = 1'b0;
        br_funct3 = 3'b000;
        illegal   = !legal;
        if (legal) begin
            alu_ctrl  = ctrl;
            op_a      = rs_1_data;
            op_b      = shift_imm ? imm_sh : (use_imm ? imm_i : rs_2_data);
            is_branch = branch;
            br_funct3 = branch ? funct3 : 3'b000;
        end
    end

endmodule

// File: rtl/id_ex_alu_ctrl_stage.sv
// One-entry ID/EX register slot with valid/ready handshake and flush around alu_ctrl_decode.
module id_ex_alu_ctrl_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    id_ex_alu_ctrl_stage_if.slave  bus
);
    logic [CTRL_W-1:0] dec_ctrl;
    logic [XLEN-1:0]   dec_a;
    logic [XLEN-1:0]   dec_b;
    logic              dec_branch;
    logic [2:0]        dec_f3;
    logic              dec_illegal;

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              branch_q;
    logic [2:0]        f3_q;
    logic              illegal_q;
    logic              in_ready;
    logic              capture;

    alu_ctrl_decode #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) u_decode (
        .instr     (bus.instr),
        .rs_1_data (bus.rs_1_data),
        .rs_2_data (bus.rs_2_data),
        .alu_ctrl  (dec_ctrl),
        .op_a      (dec_a),
        .op_b      (dec_b),
        .is_branch (dec_branch),
        .br_funct3 (dec_f3),
        .illegal   (dec_illegal)
    );

    assign in_ready = !valid_q || bus.out_ready;
    assign capture  = bus.in_valid && in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            branch_q  <= 1'b0;
            f3_q      <= 3'b000;
            illegal_q <= 1'b0;
        end else begin
            // Flush beats capture; a consumed entry with no replacement just drops valid.
            if (bus.flush)          valid_q <= 1'b0;
            else if (capture)       valid_q <= 1'b1;
            else if (bus.out_ready) valid_q <= 1'b0;

            if (capture) begin
                ctrl_q    <= dec_ctrl;
                a_q       <= dec_a;
                b_q       <= dec_b;
                branch_q  <= dec_branch;
                f3_q      <= dec_f3;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.alu_ctrl  = ctrl_q;
    assign bus.op_a      = a_q;
    assign bus.op_b      = b_q;
    assign bus.is_branch = branch_q;
    assign bus.br_funct3 = f3_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_ctrl_stage.sv
// Bench for id_ex_alu_ctrl_stage: directed vector table, stall/flush/reset sequences, random traffic vs model.
module tb_id_ex_alu_ctrl_stage;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } entry_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        entry_t      exp;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic   m_valid;
    entry_t m_entry;

    id_ex_alu_ctrl_stage_if #(.XLEN(32), .CTRL_W(4)) bus ();

    id_ex_alu_ctrl_stage #(.XLEN(32), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Table-based reference decode from the instruction-set rules.
    function automatic entry_t model_decode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        entry_t     e;
        logic [3:0] base_tab [8];
        logic [3:0] br_tab [8];
        logic [6:0] opc;
        logic [6:0] f7;
        int         f3;
        logic       legal;
        base_tab = '{4'h0, 4'h2, 4'h8, 4'h9, 4'h5, 4'h3, 4'h6, 4'h7};
        br_tab   = '{4'h1, 4'h1, 4'hF, 4'hF, 4'h8, 4'h8, 4'h9, 4'h9};
        opc   = ins[6:0];
        f7    = ins[31:25];
        f3    = int'(ins[14:12]);
        e     = '0;
        legal = 1'b0;
        if (opc == 7'h33) begin
            e.a = r1;
            e.b = r2;
            if (f7 == 7'h00)                 begin legal = 1'b1; e.ctrl = base_tab[f3]; end
            else if (f7 == 7'h20 && f3 == 0) begin legal = 1'b1; e.ctrl = 4'h1; end
            else if (f7 == 7'h20 && f3 == 5) begin legal = 1'b1; e.ctrl = 4'h4; end
        end else if (opc == 7'h13) begin
            e.a = r1;
            if (f3 == 1 || f3 == 5) begin
                e.b    = {27'd0, ins[24:20]};
                legal  = (f7 == 7'h00) || (f3 == 5 && f7 == 7'h20);
                e.ctrl = (f7 == 7'h20) ? 4'h4 : base_tab[f3];
            end else begin
                e.b    = {{20{ins[31]}}, ins[31:20]};
                legal  = 1'b1;
                e.ctrl = base_tab[f3];
            end
        end else if (opc == 7'h63) begin
            e.a    = r1;
            e.b    = r2;
            e.ctrl = br_tab[f3];
            legal  = (br_tab[f3] != 4'hF);
            e.br   = 1'b1;
            e.f3   = ins[14:12];
        end
        if (!legal) e = '0;
        e.ill = !legal;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input logic exp_valid, input entry_t exp);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_valid});
        chk({tag, ".alu_ctrl"},  {28'd0, bus.alu_ctrl},  {28'd0, exp.ctrl});
        chk({tag, ".op_a"},      bus.op_a,               exp.a);
        chk({tag, ".op_b"},      bus.op_b,               exp.b);
        chk({tag, ".is_branch"}, {31'd0, bus.is_branch}, {31'd0, exp.br});
        chk({tag, ".br_funct3"}, {29'd0, bus.br_funct3}, {29'd0, exp.f3});
        chk({tag, ".illegal"},   {31'd0, bus.illegal},   {31'd0, exp.ill});
    endtask

    // Applies inputs for one cycle; checks in_ready before the edge, advances the model on it.
    task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic rdy;
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.instr     = ins;
        bus.rs_1_data = a;
        bus.rs_2_data = b;
        #1;
        rdy = !m_valid || ordy;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_entry = '0;
        end else if (f) begin
            m_valid = 1'b0;
        end else if (iv && rdy) begin
            m_valid = 1'b1;
            m_entry = model_decode(ins, a, b);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    vec_t        vecs [$];
    entry_t      held;
    entry_t      zero_e;
    logic [31:0] ins;
    logic [6:0]  opc_pick [4];

    function automatic entry_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic br, input logic [2:0] f3, input logic ill);
        entry_t e;
        e.ctrl = c; e.a = a; e.b = b; e.br = br; e.f3 = f3; e.ill = ill;
        return e;
    endfunction

    initial begin
        tests   = 0;
        fails   = 0;
        m_valid = 1'b0;
        m_entry = '0;
        zero_e  = '0;

        vecs.push_back('{"slt",      32'h0020A1B3, 32'hFFFFFFFF, 32'h00000001, mk(4'h8, 32'hFFFFFFFF, 32'h00000001, 0, 3'd0, 0)});
        vecs.push_back('{"sltiu",    32'hFFF0B193, 32'h00000005, 32'h12345678, mk(4'h9, 32'h00000005, 32'hFFFFFFFF, 0, 3'd0, 0)});
        vecs.push_back('{"srai",     32'h4040D193, 32'h80000000, 32'h0000000F, mk(4'h4, 32'h80000000, 32'h00000004, 0, 3'd0, 0)});
        vecs.push_back('{"slli_bad", 32'h40409193, 32'hDEADBEEF, 32'h11111111, mk(4'h0, 32'h0,        32'h0,        0, 3'd0, 1)});
        vecs.push_back('{"bltu",     32'h0020E063, 32'h00000003, 32'h00000004, mk(4'h9, 32'h00000003, 32'h00000004, 1, 3'd6, 0)});
        vecs.push_back('{"add",      32'h002081B3, 32'h00000010, 32'h00000020, mk(4'h0, 32'h00000010, 32'h00000020, 0, 3'd0, 0)});
        vecs.push_back('{"sub",      32'h402081B3, 32'h00000030, 32'h00000001, mk(4'h1, 32'h00000030, 32'h00000001, 0, 3'd0, 0)});
        vecs.push_back('{"sra",      32'h4020D1B3, 32'hF0000000, 32'h00000002, mk(4'h4, 32'hF0000000, 32'h00000002, 0, 3'd0, 0)});
        vecs.push_back('{"xor",      32'h0020C1B3, 32'hAAAA5555, 32'h0F0F0F0F, mk(4'h5, 32'hAAAA5555, 32'h0F0F0F0F, 0, 3'd0, 0)});
        vecs.push_back('{"mul_bad",  32'h022081B3, 32'h00000002, 32'h00000003, mk(4'h0, 32'h0,        32'h0,        0, 3'd0, 1)});
        vecs.push_back('{"sllalt",   32'h402091B3, 32'h00000002, 32'h00000003, mk(4'h0, 32'h0,        32'h0,        0, 3'd0, 1)});
        vecs.push_back('{"addi_neg", 32'h80008193, 32'h00000100, 32'h00000000, mk(4'h0, 32'h00000100, 32'hFFFFF800, 0, 3'd0, 0)});
        vecs.push_back('{"andi_max", 32'h7FF0F193, 32'hFFFFFFFF, 32'h00000000, mk(4'h7, 32'hFFFFFFFF, 32'h000007FF, 0, 3'd0, 0)});
        vecs.push_back('{"ori",      32'h0010E193, 32'h00000040, 32'h00000000, mk(4'h6, 32'h00000040, 32'h00000001, 0, 3'd0, 0)});
        vecs.push_back('{"slli",     32'h00309193, 32'h00000001, 32'h00000000, mk(4'h2, 32'h00000001, 32'h00000003, 0, 3'd0, 0)});
        vecs.push_back('{"srli31",   32'h01F0D193, 32'h80000000, 32'h00000000, mk(4'h3, 32'h80000000, 32'h0000001F, 0, 3'd0, 0)});
        vecs.push_back('{"beq",      32'h00208063, 32'h00000007, 32'h00000007, mk(4'h1, 32'h00000007, 32'h00000007, 1, 3'd0, 0)});
        vecs.push_back('{"bge",      32'h0020D063, 32'hFFFFFFFE, 32'h00000001, mk(4'h8, 32'hFFFFFFFE, 32'h00000001, 1, 3'd5, 0)});
        vecs.push_back('{"br_bad",   32'h0020A063, 32'h00000001, 32'h00000002, mk(4'h0, 32'h0,        32'h0,        0, 3'd0, 1)});
        vecs.push_back('{"load_bad", 32'h0000A183, 32'h00001000, 32'h00000000, mk(4'h0, 32'h0,        32'h0,        0, 3'd0, 1)});

        // Reset state
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h002081B3, 32'h1, 32'h2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h002081B3, 32'h1, 32'h2);
        check_outputs("reset", 1'b0, zero_e);

        // Directed vectors, one per cycle with the consumer always ready
        foreach (vecs[i]) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            check_outputs(vecs[i].name, 1'b1, vecs[i].exp);
        end

        // Drain with no new capture: valid drops, data holds
        held = vecs[vecs.size()-1].exp;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        check_outputs("drain", 1'b0, held);

        // Capture ADD, stall three cycles with a competing instruction offered
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h00000007, 32'h00000009);
        held = mk(4'h0, 32'h00000007, 32'h00000009, 0, 3'd0, 0);
        check_outputs("cap_add", 1'b1, held);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h402081B3, 32'h11111111, 32'h22222222);
            check_outputs("stall", 1'b1, held);
            chk("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
        end

        // Flush with in_valid: entry dies, nothing captured
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h402081B3, 32'h11111111, 32'h22222222);
        chk("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("post_flush.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Flush with ready consumer and empty slot still blocks capture
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0020A1B3, 32'h3, 32'h4);
        chk("flush_empty.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a stall
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0020A1B3, 32'h5, 32'h6);
        check_outputs("cap_slt", 1'b1, mk(4'h8, 32'h5, 32'h6, 0, 3'd0, 0));
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h7, 32'h8);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h002081B3, 32'h7, 32'h8);
        check_outputs("rst_stall", 1'b0, zero_e);

        // Random traffic against the model
        opc_pick = '{7'h33, 7'h13, 7'h63, 7'h00};
        for (int n = 0; n < 1500; n++) begin
            logic [6:0] opc;
            logic [6:0] f7;
            int         sel;
            sel = int'($urandom_range(0, 3));
            opc = (sel == 3) ? 7'($urandom) : opc_pick[sel];
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            ins = {f7, 18'($urandom), opc};
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60),
                 ins, $urandom, $urandom);
            check_outputs("rand", m_valid, m_entry);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
